// File: rtl/br_lite_local_if.sv
// br_lite_local_if: local-port adapter between a processing element (PE) and
// the router's LOCAL port.
//   TX path: the PE pushes messages into a FIFO. Each accepted message is
//   stamped with the PE address and a rolling id. The head entry is then sent
//   to the router over a four-phase req/ack handshake, held off while the
//   router reports br_busy_i.
//   RX path: flits arriving from the router are acknowledged over a four-phase
//   handshake and queued in a FIFO for the PE. CLEAR flits are acknowledged
//   but not queued.
// Ports:
//   clk_i, rst_i                            clock, async active-high reset
//   tx_valid_i/tx_ready_o/tx_data_i         PE -> TX FIFO push
//   tx_drop_o                               pulse: offered message rejected
//   rx_valid_o/rx_ready_i/rx_data_o         RX FIFO head -> PE
//   br_flit_o/br_req_o/br_ack_i/br_busy_i   to router LOCAL input
//   br_flit_i/br_req_i/br_ack_o             from router LOCAL output

package br_pkg;
  localparam int unsigned BR_ID_W  = 8;
  localparam int unsigned BR_SVC_W = 2;

  localparam logic [BR_SVC_W-1:0] BR_SVC_ALL   = 2'd0;
  localparam logic [BR_SVC_W-1:0] BR_SVC_TGT   = 2'd1;
  localparam logic [BR_SVC_W-1:0] BR_SVC_CLEAR = 2'd2;

  typedef struct packed {
    logic [BR_SVC_W-1:0] service;
    logic [15:0]         source;
    logic [15:0]         target;
    logic [BR_ID_W-1:0]  id;
    logic [15:0]         payload;
  } br_data_t;
endpackage

module br_lite_local_if
  import br_pkg::*;
#(
  parameter logic [15:0] ADDRESS  = 16'h0000,
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     tx_valid_i,
  output logic     tx_ready_o,
  input  br_data_t tx_data_i,
  output logic     tx_drop_o,
  output logic     rx_valid_o,
  input  logic     rx_ready_i,
  output br_data_t rx_data_o,
  output br_data_t br_flit_o,
  output logic     br_req_o,
  input  logic     br_ack_i,
  input  br_data_t br_flit_i,
  input  logic     br_req_i,
  output logic     br_ack_o,
  input  logic     br_busy_i
);

  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned TX_CW = TX_AW + 1;
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned RX_CW = RX_AW + 1;
  localparam logic [TX_CW-1:0] TX_FULL = TX_CW'(TX_DEPTH);
  localparam logic [RX_CW-1:0] RX_FULL = RX_CW'(RX_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_WAIT_LOW} tx_state_e;
  typedef enum logic       {RX_IDLE, RX_ACK}              rx_state_e;

  // ---------------- TX FIFO ----------------
  br_data_t           r_tx_mem [TX_DEPTH];
  logic [TX_AW-1:0]   r_tx_wr, r_tx_rd;
  logic [TX_CW-1:0]   r_tx_cnt;
  logic [TX_CW-1:0]   w_tx_cnt_nxt;
  logic [BR_ID_W-1:0] r_id_cnt;
  logic               r_tx_ready, r_tx_drop;
  logic               w_tx_svc_ok, w_tx_push, w_tx_pop;
  br_data_t           w_tx_entry;

  assign w_tx_svc_ok  = (tx_data_i.service == BR_SVC_ALL) ||
                        (tx_data_i.service == BR_SVC_TGT);
  assign w_tx_push    = tx_valid_i && r_tx_ready && w_tx_svc_ok;
  assign w_tx_cnt_nxt = r_tx_cnt + TX_CW'(w_tx_push) - TX_CW'(w_tx_pop);

  // Stamp source address and rolling id onto the PE message
  always_comb begin
    w_tx_entry        = tx_data_i;
    w_tx_entry.source = 16'(ADDRESS);
    w_tx_entry.id     = r_id_cnt;
  end

  always_ff @(posedge clk_i) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= w_tx_entry;
  end

  // Pointers, occupancy, id counter; drops are any non-ALL/TGT offer, full or not
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tx_wr    <= '0;
      r_tx_rd    <= '0;
      r_tx_cnt   <= '0;
      r_id_cnt   <= '0;
      r_tx_ready <= 1'b0;
      r_tx_drop  <= 1'b0;
    end else begin
      if (w_tx_push) begin
        r_tx_wr  <= r_tx_wr + TX_AW'(1);
        r_id_cnt <= r_id_cnt + BR_ID_W'(1);
      end
      if (w_tx_pop) r_tx_rd <= r_tx_rd + TX_AW'(1);
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_ready <= (w_tx_cnt_nxt != TX_FULL);
      r_tx_drop  <= tx_valid_i && !w_tx_svc_ok;
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_e r_tx_state, w_tx_state_nxt;
  logic      r_br_req, w_br_req_nxt;
  br_data_t  r_br_flit, w_br_flit_nxt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tx_state <= TX_IDLE;
      r_br_req   <= 1'b0;
      r_br_flit  <= '0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_br_req   <= w_br_req_nxt;
      r_br_flit  <= w_br_flit_nxt;
    end
  end

  // Busy only gates a new request; once raised, req is held until ack
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_br_req_nxt   = r_br_req;
    w_br_flit_nxt  = r_br_flit;
    w_tx_pop       = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if ((r_tx_cnt != '0) && !br_busy_i) begin
          w_tx_state_nxt = TX_REQ;
          w_br_req_nxt   = 1'b1;
          w_br_flit_nxt  = r_tx_mem[r_tx_rd];
        end
      end
      TX_REQ: begin
        if (br_ack_i) begin
          w_tx_state_nxt = TX_WAIT_LOW;
          w_br_req_nxt   = 1'b0;
          w_tx_pop       = 1'b1;
        end
      end
      TX_WAIT_LOW: begin
        if (!br_ack_i) w_tx_state_nxt = TX_IDLE;
      end
      default: begin
        w_tx_state_nxt = TX_IDLE;
        w_br_req_nxt   = 1'b0;
      end
    endcase
  end

  // ---------------- RX FIFO ----------------
  br_data_t         r_rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] r_rx_wr, r_rx_rd;
  logic [RX_CW-1:0] r_rx_cnt;
  logic [RX_CW-1:0] w_rx_cnt_nxt;
  logic             r_rx_valid;
  logic             w_rx_full, w_rx_accept, w_rx_push, w_rx_pop;

  // Fullness uses the current count only, so a pop on a full FIFO frees the
  // slot for the next cycle rather than allowing a same-cycle push
  assign w_rx_full    = (r_rx_cnt == RX_FULL);
  assign w_rx_pop     = rx_ready_i && r_rx_valid;
  assign w_rx_push    = w_rx_accept && (br_flit_i.service != BR_SVC_CLEAR);
  assign w_rx_cnt_nxt = r_rx_cnt + RX_CW'(w_rx_push) - RX_CW'(w_rx_pop);

  always_ff @(posedge clk_i) begin
    if (w_rx_push) r_rx_mem[r_rx_wr] <= br_flit_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rx_wr    <= '0;
      r_rx_rd    <= '0;
      r_rx_cnt   <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + RX_AW'(1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + RX_AW'(1);
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_valid <= (w_rx_cnt_nxt != '0);
    end
  end

  // ---------------- RX FSM ----------------
  rx_state_e r_rx_state, w_rx_state_nxt;
  logic      r_br_ack, w_br_ack_nxt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rx_state <= RX_IDLE;
      r_br_ack   <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_br_ack   <= w_br_ack_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_br_ack_nxt   = r_br_ack;
    w_rx_accept    = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (br_req_i && !w_rx_full) begin
          w_rx_accept    = 1'b1;
          w_rx_state_nxt = RX_ACK;
          w_br_ack_nxt   = 1'b1;
        end
      end
      RX_ACK: begin
        if (!br_req_i) begin
          w_rx_state_nxt = RX_IDLE;
          w_br_ack_nxt   = 1'b0;
        end
      end
      default: begin
        w_rx_state_nxt = RX_IDLE;
        w_br_ack_nxt   = 1'b0;
      end
    endcase
  end

  assign tx_ready_o = r_tx_ready;
  assign tx_drop_o  = r_tx_drop;
  assign br_req_o   = r_br_req;
  assign br_flit_o  = r_br_flit;
  assign br_ack_o   = r_br_ack;
  assign rx_valid_o = r_rx_valid;
  assign rx_data_o  = r_rx_mem[r_rx_rd];

endmodule

// File: tb/tb_br_lite_local_if.sv
// Directed bench for br_lite_local_if (ADDRESS=0x0101, 4-entry FIFOs).
module tb_br_lite_local_if;
  import br_pkg::*;

  logic     clk_i = 1'b0;
  logic     rst_i;
  logic     tx_valid_i, tx_ready_o, tx_drop_o;
  br_data_t tx_data_i;
  logic     rx_valid_o, rx_ready_i;
  br_data_t rx_data_o;
  br_data_t br_flit_o, br_flit_i;
  logic     br_req_o, br_ack_i, br_req_i, br_ack_o, br_busy_i;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  br_lite_local_if #(
    .ADDRESS (16'h0101),
    .TX_DEPTH(4),
    .RX_DEPTH(4)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .tx_valid_i(tx_valid_i),
    .tx_ready_o(tx_ready_o),
    .tx_data_i (tx_data_i),
    .tx_drop_o (tx_drop_o),
    .rx_valid_o(rx_valid_o),
    .rx_ready_i(rx_ready_i),
    .rx_data_o (rx_data_o),
    .br_flit_o (br_flit_o),
    .br_req_o  (br_req_o),
    .br_ack_i  (br_ack_i),
    .br_flit_i (br_flit_i),
    .br_req_i  (br_req_i),
    .br_ack_o  (br_ack_o),
    .br_busy_i (br_busy_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Source/id carry junk: the DUT must overwrite them
  function automatic br_data_t mk(input logic [1:0] svc, input logic [15:0] tgt,
                                  input logic [15:0] pl);
    br_data_t d;
    d.service = svc;
    d.source  = 16'hFFFF;
    d.target  = tgt;
    d.id      = 8'hAA;
    d.payload = pl;
    return d;
  endfunction

  task automatic push(input br_data_t d);
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    tick();
    tx_valid_i = 1'b0;
  endtask

  task automatic tx_handshake();
    br_ack_i = 1'b1;
    tick();
    br_ack_i = 1'b0;
    tick();
  endtask

  task automatic rx_send(input br_data_t d);
    br_flit_i = d;
    br_req_i  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (br_ack_o) break;
      tick();
    end
    chk("rx_send_ack_hi", 32'(br_ack_o), 32'd1);
    br_req_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!br_ack_o) break;
      tick();
    end
    chk("rx_send_ack_lo", 32'(br_ack_o), 32'd0);
  endtask

  initial begin
    rst_i      = 1'b1;
    tx_valid_i = 1'b0;
    tx_data_i  = '0;
    rx_ready_i = 1'b0;
    br_ack_i   = 1'b0;
    br_flit_i  = '0;
    br_req_i   = 1'b0;
    br_busy_i  = 1'b0;
    tick();
    tick();

    // Held in reset
    chk("rst_tx_ready", 32'(tx_ready_o), 32'd0);
    chk("rst_req",      32'(br_req_o),   32'd0);
    chk("rst_ack",      32'(br_ack_o),   32'd0);
    chk("rst_rx_valid", 32'(rx_valid_o), 32'd0);
    chk("rst_drop",     32'(tx_drop_o),  32'd0);

    // Release
    rst_i = 1'b0;
    tick();
    chk("rel_tx_ready", 32'(tx_ready_o), 32'd1);
    chk("rel_req",      32'(br_req_o),   32'd0);
    chk("rel_ack",      32'(br_ack_o),   32'd0);
    chk("rel_rx_valid", 32'(rx_valid_o), 32'd0);

    // First push: stamped source/id, req one cycle after push edge
    push(mk(BR_SVC_TGT, 16'h0202, 16'hCAFE));
    chk("req_not_yet", 32'(br_req_o), 32'd0);
    tick();
    chk("req_up",       32'(br_req_o),          32'd1);
    chk("flit_source",  32'(br_flit_o.source),  32'h0101);
    chk("flit_id0",     32'(br_flit_o.id),      32'd0);
    chk("flit_target",  32'(br_flit_o.target),  32'h0202);
    chk("flit_payload", 32'(br_flit_o.payload), 32'hCAFE);
    chk("flit_service", 32'(br_flit_o.service), 32'(BR_SVC_TGT));
    tick();
    tick();
    chk("req_held",     32'(br_req_o),          32'd1);
    chk("flit_held",    32'(br_flit_o.payload), 32'hCAFE);
    br_ack_i = 1'b1;
    tick();
    chk("req_drop_on_ack", 32'(br_req_o), 32'd0);
    br_ack_i = 1'b0;
    tick();

    // Second push carries id 1
    push(mk(BR_SVC_ALL, 16'h0000, 16'h1234));
    tick();
    chk("req2_up",  32'(br_req_o),     32'd1);
    chk("flit_id1", 32'(br_flit_o.id), 32'd1);
    tx_handshake();

    // Router busy holds off the request
    br_busy_i = 1'b1;
    push(mk(BR_SVC_TGT, 16'h0303, 16'hBEEF));
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("busy_no_req", 32'(br_req_o), 32'd0);
    end
    br_busy_i = 1'b0;
    tick();
    chk("busy_release_req", 32'(br_req_o),     32'd1);
    chk("flit_id2",         32'(br_flit_o.id), 32'd2);
    tx_handshake();

    // CLEAR and undefined service are dropped
    push(mk(BR_SVC_CLEAR, 16'h0000, 16'h0000));
    chk("clear_drop_pulse", 32'(tx_drop_o), 32'd1);
    chk("clear_no_req",     32'(br_req_o),  32'd0);
    tick();
    chk("clear_drop_end",   32'(tx_drop_o), 32'd0);
    chk("clear_no_req2",    32'(br_req_o),  32'd0);
    push(mk(2'd3, 16'h0000, 16'h0000));
    chk("undef_drop_pulse", 32'(tx_drop_o), 32'd1);
    tick();
    chk("undef_drop_end",   32'(tx_drop_o), 32'd0);
    chk("undef_no_req",     32'(br_req_o),  32'd0);
    push(mk(BR_SVC_TGT, 16'h0404, 16'h5555));
    tick();
    chk("post_drop_req", 32'(br_req_o),     32'd1);
    chk("flit_id3",      32'(br_flit_o.id), 32'd3);
    tx_handshake();

    // Fill TX FIFO while busy, then drop when full
    br_busy_i  = 1'b1;
    tx_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_data_i = mk(BR_SVC_TGT, 16'h0000, 16'(i));
      tick();
    end
    chk("tx_full_not_ready", 32'(tx_ready_o), 32'd0);
    tx_data_i = mk(BR_SVC_CLEAR, 16'h0000, 16'h0000);
    tick();
    tx_valid_i = 1'b0;
    chk("full_drop_pulse", 32'(tx_drop_o), 32'd1);
    br_busy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_req",     32'(br_req_o),          32'd1);
      chk("drain_id",      32'(br_flit_o.id),      32'(4 + i));
      chk("drain_payload", 32'(br_flit_o.payload), 32'(i));
      br_ack_i = 1'b1;
      tick();
      chk("drain_req_lo",  32'(br_req_o), 32'd0);
      br_ack_i = 1'b0;
      tick();
    end
    chk("drained_ready", 32'(tx_ready_o), 32'd1);

    // RX: first flit, then fill to 4
    br_flit_i = mk(BR_SVC_ALL, 16'h0101, 16'h0001);
    br_req_i  = 1'b1;
    tick();
    chk("rx_ack_hi",    32'(br_ack_o),          32'd1);
    chk("rx_valid_hi",  32'(rx_valid_o),        32'd1);
    chk("rx_head_1",    32'(rx_data_o.payload), 32'h0001);
    br_req_i = 1'b0;
    tick();
    chk("rx_ack_lo",    32'(br_ack_o), 32'd0);
    for (int i = 2; i <= 4; i++) rx_send(mk(BR_SVC_TGT, 16'h0101, 16'(i)));
    chk("rx_full_head", 32'(rx_data_o.payload), 32'h0001);

    // Fifth flit back-pressured until a pop
    br_flit_i = mk(BR_SVC_ALL, 16'h0101, 16'h0005);
    br_req_i  = 1'b1;
    tick();
    tick();
    tick();
    chk("rx_backpressure", 32'(br_ack_o), 32'd0);
    rx_ready_i = 1'b1;
    tick();
    rx_ready_i = 1'b0;
    chk("rx_pop_no_ack", 32'(br_ack_o), 32'd0);
    tick();
    chk("rx_ack_after_pop", 32'(br_ack_o),          32'd1);
    chk("rx_head_2",        32'(rx_data_o.payload), 32'h0002);
    br_req_i = 1'b0;
    tick();
    chk("rx_ack5_lo", 32'(br_ack_o), 32'd0);
    for (int i = 2; i <= 5; i++) begin
      chk("rx_drain_valid", 32'(rx_valid_o),        32'd1);
      chk("rx_drain_data",  32'(rx_data_o.payload), 32'(i));
      rx_ready_i = 1'b1;
      tick();
      rx_ready_i = 1'b0;
    end
    chk("rx_empty", 32'(rx_valid_o), 32'd0);

    // Incoming CLEAR: acked, not queued
    br_flit_i = mk(BR_SVC_CLEAR, 16'h0101, 16'h0000);
    br_req_i  = 1'b1;
    tick();
    chk("rx_clear_ack",   32'(br_ack_o),   32'd1);
    chk("rx_clear_valid", 32'(rx_valid_o), 32'd0);
    br_req_i = 1'b0;
    tick();
    chk("rx_clear_ack_lo", 32'(br_ack_o),   32'd0);
    chk("rx_clear_valid2", 32'(rx_valid_o), 32'd0);

    // Reset during a held request
    push(mk(BR_SVC_TGT, 16'h0505, 16'h7777));
    tick();
    chk("pre_rst_req", 32'(br_req_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("rst_req_async",   32'(br_req_o),   32'd0);
    chk("rst_ready_async", 32'(tx_ready_o), 32'd0);
    tick();
    rst_i = 1'b0;
    tick();
    chk("rst2_ready", 32'(tx_ready_o), 32'd1);
    tick();
    tick();
    chk("rst2_fifo_empty", 32'(br_req_o), 32'd0);
    push(mk(BR_SVC_TGT, 16'h0606, 16'h8888));
    tick();
    chk("rst2_req",      32'(br_req_o),          32'd1);
    chk("rst2_id0",      32'(br_flit_o.id),      32'd0);
    chk("rst2_payload",  32'(br_flit_o.payload), 32'h8888);
    tx_handshake();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/br_lite_local_if.md
BR_LITE_LOCAL_IF -- requirements
Module: br_lite_local_if

Interface
REQ-001 SHALL have parameter ADDRESS, default 0: 16-bit PE address, inserted as source of every injected flit.
REQ-002 SHALL have parameter TX_DEPTH, default 4: TX FIFO entries, a power of two of at least 2.
REQ-003 SHALL have parameter RX_DEPTH, default 4: RX FIFO entries, a power of two of at least 2.
REQ-004 SHALL have port clk_i, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port tx_valid_i, input, 1 bit: PE offers a message.
REQ-007 SHALL have port tx_ready_o, output, 1 bit: TX FIFO not full.
REQ-008 SHALL have port tx_data_i, input, br_data_t: PE message; source and id fields ignored.
REQ-009 SHALL have port tx_drop_o, output, 1 bit: one-cycle pulse when an offered message is rejected.
REQ-010 SHALL have port rx_valid_o, output, 1 bit: RX FIFO not empty.
REQ-011 SHALL have port rx_ready_i, input, 1 bit: PE pops the RX head.
REQ-012 SHALL have port rx_data_o, output, br_data_t: RX FIFO head.
REQ-013 SHALL have port br_flit_o, output, br_data_t: flit to the router LOCAL input.
REQ-014 SHALL have port br_req_o, output, 1 bit: request to the router LOCAL input.
REQ-015 SHALL have port br_ack_i, input, 1 bit: acknowledge from the router LOCAL input.
REQ-016 SHALL have port br_flit_i, input, br_data_t: flit from the router LOCAL output.
REQ-017 SHALL have port br_req_i, input, 1 bit: request from the router LOCAL output.
REQ-018 SHALL have port br_ack_o, output, 1 bit: acknowledge to the router LOCAL output.
REQ-019 SHALL have port br_busy_i, input, 1 bit: router local_busy (an own broadcast is still held in the CAM).

Function
REQ-020 SHALL accept a TX push when tx_valid_i && tx_ready_o && service is BR_SVC_ALL or BR_SVC_TGT.
REQ-021 SHALL store the pushed entry with source=16'(ADDRESS) and id=id_cnt, then increment id_cnt, which wraps modulo the id field width.
REQ-022 SHALL, when tx_valid_i is high with service BR_SVC_CLEAR or any undefined code: store nothing, leave id_cnt unchanged, and pulse tx_drop_o for 1 cycle even if the FIFO is full.
REQ-023 SHALL run the TX FSM TX_IDLE -> TX_REQ -> TX_WAIT_LOW -> TX_IDLE.
REQ-024 SHALL move TX_IDLE -> TX_REQ when the TX FIFO is non-empty and br_busy_i=0; br_req_o=1 and br_flit_o=head are registered at that edge.
REQ-025 SHALL stay in TX_REQ, holding br_req_o=1 and br_flit_o stable, until br_ack_i=1.
REQ-026 SHALL, on br_ack_i=1 in TX_REQ: clear br_req_o, pop the head, and enter TX_WAIT_LOW.
REQ-027 SHALL leave TX_WAIT_LOW for TX_IDLE only once br_ack_i=0 (four-phase handshake).
REQ-028 SHALL ignore br_busy_i while in TX_REQ; a held request is never withdrawn.
REQ-029 SHALL run the RX FSM RX_IDLE -> RX_ACK -> RX_IDLE.
REQ-030 SHALL, in RX_IDLE with br_req_i=1 and the RX FIFO not full: capture br_flit_i, set br_ack_o=1, and enter RX_ACK.
REQ-031 SHALL, if the captured service is BR_SVC_CLEAR, still acknowledge the flit but discard it rather than enqueue it.
REQ-032 SHALL hold br_ack_o=0 and stay in RX_IDLE while the RX FIFO is full (backpressure).
REQ-033 SHALL, in RX_ACK, clear br_ack_o and return to RX_IDLE once br_req_i=0.
REQ-034 SHALL, on a same-cycle push and pop of a full RX FIFO, perform the pop only; br_ack_o rises the next cycle.
REQ-035 SHALL let the TX path and the RX path operate concurrently and independently.
REQ-036 SHALL use a TX/RX FIFO latency of 1 cycle (push to valid) and follow first-word-fall-through order.

Reset
REQ-037 SHALL, while rst_i=1, hold br_req_o=0, br_ack_o=0, tx_drop_o=0, rx_valid_o=0, tx_ready_o=0; both FIFOs empty; id_cnt=0; FSMs in TX_IDLE and RX_IDLE.
REQ-038 SHALL assert tx_ready_o=1 in the first cycle after rst_i falls.
REQ-039 SHALL, on reset during a handshake, abandon it immediately; the entry in flight is lost.

Verification
REQ-040 SHALL cover: reset released -> tx_ready_o=1, br_req_o=0, br_ack_o=0, rx_valid_o=0.
REQ-041 SHALL cover: ADDRESS=0x0101 push {TGT, target 0x0202, payload 0xCAFE} -> br_req_o=1 within 2 cycles, br_flit_o.source=0x0101, id=0; ack high -> br_req_o=0 on the next cycle; second push carries id=1.
REQ-042 SHALL cover: br_busy_i=1 with 1 queued entry -> br_req_o=0 for 20 cycles; busy drops -> br_req_o=1 on the next cycle.
REQ-043 SHALL cover: RX_DEPTH=4, four flits received and rx_ready_i=0, fifth br_req_i=1 -> br_ack_o stays 0; one pop -> br_ack_o=1 on the next cycle.
REQ-044 SHALL cover: push with service CLEAR -> tx_drop_o pulses for 1 cycle, no request, id_cnt unchanged; incoming CLEAR flit -> acked, rx_valid_o stays 0.
REQ-045 SHALL cover: rst_i=1 while br_req_o=1 -> br_req_o=0 in the same cycle, FIFO empty after release.
